// File: rtl/global_pkg.sv
// Shared types for the bus decoder: FSM states, error causes and the address
// window descriptor used to build the slave memory map.
package global_pkg;

    localparam int ADDR_W = 32;
    localparam int WAIT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNMAPPED = 2'd1,
        ERR_SLAVE    = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_cause_t;

    // Inclusive window: low <= addr <= high
    typedef struct packed {
        logic [ADDR_W-1:0] high;
        logic [ADDR_W-1:0] low;
    } memory_map_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr_match.sv
// Combinational address decoder: flags every slave window containing adr and
// reports the lowest-indexed hit so overlapping windows resolve deterministically.
module addr_match
    import global_pkg::*;
#(
    parameter int                           N_SLAVES = 4,
    parameter memory_map_t [N_SLAVES-1:0]   MAP      = '0,
    localparam int                          IDX_W    = idx_width(N_SLAVES)
) (
    input  logic [ADDR_W-1:0] adr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    logic [N_SLAVES-1:0] match_s;

    function automatic logic [IDX_W-1:0] first_set(input logic [N_SLAVES-1:0] vec);
        first_set = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                first_set = IDX_W'(i);
            end
        end
    endfunction

    // Offset-from-low compare keeps the range test unsigned and wrap-safe
    always_comb begin
        match_s = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            match_s[i] = (MAP[i].high >= MAP[i].low) &&
                         ((adr - MAP[i].low) <= (MAP[i].high - MAP[i].low));
        end
    end

    // Reduce the match vector to a hit flag and a priority-encoded index
    always_comb begin
        hit = |match_s;
        idx = first_set(match_s);
    end

endmodule

// File: rtl/bus_decoder.sv
// Single-master to N-slave bus decoder with unmapped-address, slave-error and
// timeout reporting. One outstanding request at a time, IDLE -> BUSY -> RESP.
module bus_decoder
    import global_pkg::*;
#(
    parameter int                           N_SLAVES = 4,
    parameter int                           DATA_W   = 32,
    parameter int                           TIMEOUT  = 255,
    parameter memory_map_t [N_SLAVES-1:0]   MAP      = '0,
    localparam int                          SEL_W    = DATA_W / 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             m_cyc,
    input  logic                             m_stb,
    input  logic                             m_we,
    input  logic [ADDR_W-1:0]                m_adr,
    input  logic [DATA_W-1:0]                m_dat_w,
    input  logic [SEL_W-1:0]                 m_sel,
    output logic [DATA_W-1:0]                m_dat_r,
    output logic                             m_ack,
    output logic                             m_err,
    output logic [N_SLAVES-1:0]              s_stb,
    output logic                             s_we,
    output logic [ADDR_W-1:0]                s_adr,
    output logic [DATA_W-1:0]                s_dat_w,
    output logic [SEL_W-1:0]                 s_sel,
    input  logic [N_SLAVES-1:0][DATA_W-1:0]  s_dat_r,
    input  logic [N_SLAVES-1:0]              s_ack,
    input  logic [N_SLAVES-1:0]              s_err,
    output logic [ADDR_W-1:0]                err_addr,
    output logic [1:0]                       err_cause
);

    localparam int IDX_W = idx_width(N_SLAVES);

    bus_state_t            state_q,     state_d;
    logic [IDX_W-1:0]      idx_q,       idx_d;
    logic                  we_q,        we_d;
    logic [ADDR_W-1:0]     adr_q,       adr_d;
    logic [DATA_W-1:0]     dat_w_q,     dat_w_d;
    logic [SEL_W-1:0]      sel_q,       sel_d;
    logic [N_SLAVES-1:0]   s_stb_q,     s_stb_d;
    logic                  m_ack_q,     m_ack_d;
    logic                  m_err_q,     m_err_d;
    logic [DATA_W-1:0]     m_dat_r_q,   m_dat_r_d;
    logic [WAIT_W-1:0]     wait_q,      wait_d;
    logic [ADDR_W-1:0]     err_addr_q,  err_addr_d;
    err_cause_t            err_cause_q, err_cause_d;

    logic                  hit_s;
    logic [IDX_W-1:0]      hit_idx_s;
    logic [WAIT_W-1:0]     wait_inc_s;

    addr_match #(
        .N_SLAVES (N_SLAVES),
        .MAP      (MAP)
    ) u_addr_match (
        .adr (m_adr),
        .hit (hit_s),
        .idx (hit_idx_s)
    );

    // Next-state and next-output logic for the request FSM
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_w_d     = dat_w_q;
        sel_d       = sel_q;
        s_stb_d     = s_stb_q;
        m_ack_d     = 1'b0;
        m_err_d     = 1'b0;
        m_dat_r_d   = m_dat_r_q;
        wait_d      = wait_q;
        err_addr_d  = err_addr_q;
        err_cause_d = err_cause_q;
        wait_inc_s  = wait_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (m_cyc && m_stb) begin
                    adr_d   = m_adr;
                    we_d    = m_we;
                    dat_w_d = m_dat_w;
                    sel_d   = m_sel;
                    idx_d   = hit_idx_s;
                    if (hit_s) begin
                        state_d = BUSY;
                        s_stb_d = N_SLAVES'(1'b1) << hit_idx_s;
                        wait_d  = 16'd0;
                    end else begin
                        state_d     = RESP;
                        m_err_d     = 1'b1;
                        err_cause_d = ERR_UNMAPPED;
                        err_addr_d  = m_adr;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // A master abort outranks any response arriving in the same cycle
                if (!m_cyc) begin
                    state_d = IDLE;
                    s_stb_d = '0;
                end else if (s_err[idx_q]) begin
                    state_d     = RESP;
                    s_stb_d     = '0;
                    m_err_d     = 1'b1;
                    err_cause_d = ERR_SLAVE;
                    err_addr_d  = adr_q;
                end else if (s_ack[idx_q]) begin
                    state_d   = RESP;
                    s_stb_d   = '0;
                    m_ack_d   = 1'b1;
                    m_dat_r_d = s_dat_r[idx_q];
                end else if (wait_inc_s == 16'(TIMEOUT)) begin
                    state_d     = RESP;
                    s_stb_d     = '0;
                    m_err_d     = 1'b1;
                    err_cause_d = ERR_TIMEOUT;
                    err_addr_d  = adr_q;
                    wait_d      = wait_inc_s;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                s_stb_d = '0;
            end
        endcase
    end

    // State and output registers; reset clears everything, including s_stb
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_w_q     <= '0;
            sel_q       <= '0;
            s_stb_q     <= '0;
            m_ack_q     <= 1'b0;
            m_err_q     <= 1'b0;
            m_dat_r_q   <= '0;
            wait_q      <= '0;
            err_addr_q  <= '0;
            err_cause_q <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_w_q     <= dat_w_d;
            sel_q       <= sel_d;
            s_stb_q     <= s_stb_d;
            m_ack_q     <= m_ack_d;
            m_err_q     <= m_err_d;
            m_dat_r_q   <= m_dat_r_d;
            wait_q      <= wait_d;
            err_addr_q  <= err_addr_d;
            err_cause_q <= err_cause_d;
        end
    end

    assign m_dat_r   = m_dat_r_q;
    assign m_ack     = m_ack_q;
    assign m_err     = m_err_q;
    assign s_stb     = s_stb_q;
    assign s_we      = we_q;
    assign s_adr     = adr_q;
    assign s_dat_w   = dat_w_q;
    assign s_sel     = sel_q;
    assign err_addr  = err_addr_q;
    assign err_cause = err_cause_q;

endmodule
